uart_rx_param: RTL and testbench

//   Parametrised UART receiver; successor to the fixed 8N1 receiver.
//   - Configurable data width, parity mode and stop-bit count.
//   - Start-bit validation; parity, framing and overrun detection.
//   - Valid/ready output holding register.
//   - Sits between the board RX pin and the command/character decoder feeding the VGA text path.

---
 rtl/uart_rx_param_if.sv | 12 +
 rtl/uart_rx_param.sv | 136 +++++++++++++
 tb/tb_uart_rx_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer handshake bundle: a held frame with its error flags, plus the consumer's ready.
interface uart_rx_param_if;
   logic       i_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_overrun;

   modport master (input i_ready, output o_valid, o_data, o_parity_err, o_frame_err, o_overrun);
   modport slave  (output i_ready, input o_valid, o_data, o_parity_err, o_frame_err, o_overrun);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a valid/ready holding register.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote instead of a single sample.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | validating the start bit at mid-bit
// DATA      | shifting in payload bits, LSB first
// PARITY    | checking the parity bit
// STOP      | sampling stop bit(s); the last one commits the frame
// WAIT_HIGH | line stuck low after a frame; wait for it to return high
module uart_rx_param #(
   parameter int CLK_FREQ  = 25000000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rx,
   uart_rx_param_if.master    bus
);
   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int H   = CPB / 2;
   localparam int CW  = $clog2(CPB);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rx;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err, frm_err;
   logic                 sample, wrap, bit_val, commit;

   assign sample = (cnt == CW'(H - 1));
   assign wrap   = (cnt == CW'(CPB - 1));

`ifdef UART_RX_MAJORITY_EN
   logic maj_a, maj_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         maj_a <= 1'b1;
         maj_b <= 1'b1;
      end else begin
         if (cnt == CW'(H - 3)) maj_a <= rx;
         if (cnt == CW'(H - 2)) maj_b <= rx;
      end
   end

   assign bit_val = (maj_a & maj_b) | (maj_a & rx) | (maj_b & rx);
`else
   assign bit_val = rx;
`endif

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         S_IDLE:      if (!rx) state_nxt = S_START;
         S_START: begin
            if (sample && bit_val) state_nxt = S_IDLE;
            else if (wrap)         state_nxt = S_DATA;
         end
         S_DATA:      if (wrap && bit_idx == 3'(DATA_BITS - 1))
                         state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (wrap) state_nxt = S_STOP;
         S_STOP: begin
            // The final stop bit commits at mid-bit so back-to-back frames are not missed.
            if (sample && bit_idx == 3'(STOP_BITS - 1)) begin
               commit    = 1'b1;
               state_nxt = bit_val ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: if (rx) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta          <= 1'b1;
         rx               <= 1'b1;
         state            <= S_IDLE;
         cnt              <= '0;
         bit_idx          <= '0;
         shreg            <= '0;
         par_err          <= 1'b0;
         frm_err          <= 1'b0;
         bus.o_valid      <= 1'b0;
         bus.o_data       <= '0;
         bus.o_parity_err <= 1'b0;
         bus.o_frame_err  <= 1'b0;
         bus.o_overrun    <= 1'b0;
      end else begin
         rx_meta <= uart_rx;
         rx      <= rx_meta;
         state   <= state_nxt;

         if (state == S_IDLE || state_nxt == S_IDLE || state_nxt == S_WAIT_HIGH || wrap)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;

         if (state != state_nxt) bit_idx <= '0;
         else if (wrap)          bit_idx <= bit_idx + 3'd1;

         if (state == S_DATA && sample)
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};

         if (state == S_IDLE)
            par_err <= 1'b0;
         else if (state == S_PARITY && sample)
            par_err <= bit_val ^ (^shreg) ^ (PARITY == 2);

         if (state == S_IDLE)
            frm_err <= 1'b0;
         else if (state == S_STOP && sample && !bit_val)
            frm_err <= 1'b1;

         if (commit) begin
            bus.o_valid      <= 1'b1;
            bus.o_data       <= 8'(shreg);
            bus.o_parity_err <= par_err;
            bus.o_frame_err  <= frm_err | ~bit_val;
            bus.o_overrun    <= bus.o_valid & ~bus.i_ready;
         end else if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an even-parity instance at 16 clocks per bit.
module tb_uart_rx_param;
   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int H      = CPB / 2;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;

   uart_rx_param_if bus_a ();
   uart_rx_param_if bus_b ();

   uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_dut (
      .clk(clk), .rst(rst), .uart_rx(rx_a), .bus(bus_a)
   );
   uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1)) u_dut_par (
      .clk(clk), .rst(rst), .uart_rx(rx_b), .bus(bus_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-instance record of valid cycles and the last frame seen while valid.
   int         vc_a = 0, vc_b = 0;
   logic [7:0] ld_a = '0, ld_b = '0;
   logic       pe_a = 1'b0, fe_a = 1'b0, ov_a = 1'b0, pe_b = 1'b0;

   always @(negedge clk) begin
      if (bus_a.o_valid) begin
         vc_a <= vc_a + 1;
         ld_a <= bus_a.o_data;
         pe_a <= bus_a.o_parity_err;
         fe_a <= bus_a.o_frame_err;
         ov_a <= bus_a.o_overrun;
      end
      if (bus_b.o_valid) begin
         vc_b <= vc_b + 1;
         ld_b <= bus_b.o_data;
         pe_b <= bus_b.o_parity_err;
      end
   end

   task automatic line_bit(input bit sel, input logic v, input int n);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                             input logic par_v, input logic stop_v, input int glitch_bit);
      line_bit(sel, 1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit) begin
            line_bit(sel, d[i], H - 1);
            line_bit(sel, ~d[i], 1);
            line_bit(sel, d[i], CPB - H);
         end else begin
            line_bit(sel, d[i], CPB);
         end
      end
      if (par_en) line_bit(sel, par_v, CPB);
      line_bit(sel, stop_v, CPB);
   endtask

   int base;

   initial begin
      bus_a.i_ready = 1'b1;
      bus_b.i_ready = 1'b1;
      #2 rst = 1'b0;
      #20;
      check_val("rst_valid", bus_a.o_valid, 0);
      check_val("rst_data", bus_a.o_data, 0);
      check_val("rst_perr", bus_a.o_parity_err, 0);
      check_val("rst_ferr", bus_a.o_frame_err, 0);
      check_val("rst_ovr", bus_a.o_overrun, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (CPB) @(negedge clk);

      // plain 8N1 frame
      base = vc_a;
      send_frame(0, 8'h55, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("t1_count", vc_a - base, 1);
      check_val("t1_data", ld_a, 8'h55);
      check_val("t1_perr", pe_a, 0);
      check_val("t1_ferr", fe_a, 0);
      check_val("t1_ovr", ov_a, 0);

      // even parity: 0xA3 has four ones, so the correct parity bit is 0
      send_frame(1, 8'hA3, 1, 1'b1, 1'b1, -1);
      line_bit(1, 1'b1, 2 * CPB);
      check_val("t2_data_bad", ld_b, 8'hA3);
      check_val("t2_perr_bad", pe_b, 1);
      send_frame(1, 8'hA3, 1, 1'b0, 1'b1, -1);
      line_bit(1, 1'b1, 2 * CPB);
      check_val("t2_perr_ok", pe_b, 0);
      check_val("t2_count", vc_b, 2);

      // short start glitch rejected
      base = vc_a;
      line_bit(0, 1'b0, 6);
      line_bit(0, 1'b1, 3 * CPB);
      check_val("t3_glitch", vc_a - base, 0);
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("t3_count", vc_a - base, 1);
      check_val("t3_data", ld_a, 8'h3C);

      // framing error followed by a break
      base = vc_a;
      send_frame(0, 8'h7E, 0, 1'b0, 1'b0, -1);
      line_bit(0, 1'b0, 5 * CPB);
      check_val("t4_count", vc_a - base, 1);
      check_val("t4_data", ld_a, 8'h7E);
      check_val("t4_ferr", fe_a, 1);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("t4_no_repeat", vc_a - base, 1);
      send_frame(0, 8'h5A, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("t4_next_data", ld_a, 8'h5A);
      check_val("t4_next_ferr", fe_a, 0);

      // overrun with consumer stalled
      bus_a.i_ready = 1'b0;
      send_frame(0, 8'h11, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, CPB);
      check_val("t5_first_ovr", bus_a.o_overrun, 0);
      send_frame(0, 8'h22, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, CPB);
      check_val("t5_valid", bus_a.o_valid, 1);
      check_val("t5_data", bus_a.o_data, 8'h22);
      check_val("t5_ovr", bus_a.o_overrun, 1);
      bus_a.i_ready = 1'b1;
      @(negedge clk);
      check_val("t5_drop", bus_a.o_valid, 0);
      check_val("t5_hold", bus_a.o_data, 8'h22);

      // reset in the middle of a frame
      line_bit(0, 1'b0, CPB);
      line_bit(0, 1'b0, 3 * CPB + 5);
      rst = 1'b0;
      #1;
      check_val("t6_valid", bus_a.o_valid, 0);
      check_val("t6_data", bus_a.o_data, 0);
      check_val("t6_ovr", bus_a.o_overrun, 0);
      rx_a = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      line_bit(0, 1'b1, 2 * CPB);
      base = vc_a;
      send_frame(0, 8'h0F, 0, 1'b0, 1'b1, -1);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("t6_count", vc_a - base, 1);
      check_val("t6_data2", ld_a, 8'h0F);
      check_val("t6_ferr", fe_a, 0);
      check_val("t6_ovr2", ov_a, 0);

`ifdef UART_RX_MAJORITY_EN
      // one-cycle inverted pulse inside the vote window of bit 3
      base = vc_a;
      send_frame(0, 8'h55, 0, 1'b0, 1'b1, 3);
      line_bit(0, 1'b1, 2 * CPB);
      check_val("maj_count", vc_a - base, 1);
      check_val("maj_data", ld_a, 8'h55);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
